// File: rtl/bpsk_pkg.sv
// Shared constants and types for the BPSK/QPSK stream mapper.
// Symbol encoding matches the legacy combinational mapper:
// bit 0 -> +1 (2'b01), bit 1 -> -1 (2'b11), no energy -> 2'b00.
package bpsk_pkg;

  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b11;
  localparam logic [1:0] SYM_ZERO = 2'b00;

  localparam logic MODE_BPSK = 1'b0;
  localparam logic MODE_QPSK = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/bpsk_sym_map.sv
// Single-bit to 2-bit antipodal symbol mapper with an energy enable.
// Disabled lanes emit SYM_ZERO so padding and idle cycles carry no energy.
module bpsk_sym_map
  import bpsk_pkg::*;
(
  input  logic       bit_in,
  input  logic       en,
  output logic [1:0] sym
);

  // Map the bit to +1/-1, or to zero when the lane is not in use
  always_comb begin
    sym = SYM_ZERO;
    if (en) begin
      sym = bit_in ? SYM_NEG : SYM_POS;
    end
  end

endmodule

// File: rtl/bpsk_qpsk_stream_mapper.sv
// Clocked BPSK/QPSK stream mapper.
// Accepts one N-bit codeword per input handshake and serialises it LSB-first
// as BPSK (1 bit/symbol) or QPSK (2 bits/symbol) symbols on an output stream.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid && ready. A source holds its payload stable while valid && !ready;
// here the symbol outputs are pure functions of registered state, so they
// cannot change while sym_valid && !sym_ready.
//
// busy mirrors the FSM (1 = ST_SEND) and doubles as the state debug view.
module bpsk_qpsk_stream_mapper
  import bpsk_pkg::*;
#(
  parameter int N     = 12,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  output logic [1:0]   sym_i,
  output logic [1:0]   sym_q,
  output logic         sym_valid,
  input  logic         sym_ready,
  output logic         sym_last,
  output logic         busy
);

  // Counter load values: symbol count minus one for each mode
  localparam logic [CNT_W-1:0] LAST_BPSK = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_QPSK = CNT_W'((N + 1) / 2 - 1);
  // With odd N the final QPSK symbol has no partner bit for Q
  localparam logic             ODD_N     = logic'(N % 2);

  state_t           state;
  logic [N-1:0]     shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;

  logic send;
  logic at_last;
  logic sym_fire;
  logic in_fire;
  logic i_en;
  logic q_en;

  assign send     = (state == ST_SEND);
  assign at_last  = (cnt_q == '0);
  assign sym_fire = send && sym_ready;

  // Accept a new codeword when idle, or on the same edge the last symbol
  // leaves, so consecutive codewords stream without a bubble.
  assign in_ready = !rst && (!send || (sym_fire && at_last));
  assign in_fire  = in_valid && in_ready;

  assign sym_valid = send;
  assign sym_last  = send && at_last;
  assign busy      = send;

  assign i_en = send;
  assign q_en = send && (mode_q == MODE_QPSK) && !(ODD_N && at_last);

  bpsk_sym_map u_map_i (
    .bit_in (shift_q[0]),
    .en     (i_en),
    .sym    (sym_i)
  );

  bpsk_sym_map u_map_q (
    .bit_in (shift_q[1]),
    .en     (q_en),
    .sym    (sym_q)
  );

  // FSM, shift register and symbol counter; a new codeword takes priority
  // over retiring the last symbol of the previous one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_BPSK;
    end else if (in_fire) begin
      state   <= ST_SEND;
      shift_q <= in_data;
      mode_q  <= in_mode;
      cnt_q   <= (in_mode == MODE_QPSK) ? LAST_QPSK : LAST_BPSK;
    end else if (sym_fire) begin
      if (at_last) begin
        state <= ST_IDLE;
      end else begin
        shift_q <= (mode_q == MODE_QPSK) ? (shift_q >> 2) : (shift_q >> 1);
        cnt_q   <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bpsk_qpsk_stream_mapper.sv
// Self-checking bench for bpsk_qpsk_stream_mapper.
// Two instances (N=12 and N=15) share clock, reset, mode and sym_ready; one is
// selected at a time. Expected symbols come from a bit-level reference model.
module tb_bpsk_qpsk_stream_mapper;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [11:0] d12;
  logic [14:0] d15;
  logic        v12, v15;
  logic        in_mode;
  logic        sym_ready;
  logic        r12, r15, sv12, sv15, l12, l15, b12, b15;
  logic [1:0]  i12, q12, i15, q15;

  bpsk_qpsk_stream_mapper #(.N(12)) dut12 (
    .clk (clk), .rst (rst),
    .in_data (d12), .in_valid (v12), .in_ready (r12), .in_mode (in_mode),
    .sym_i (i12), .sym_q (q12), .sym_valid (sv12), .sym_ready (sym_ready),
    .sym_last (l12), .busy (b12)
  );

  bpsk_qpsk_stream_mapper #(.N(15)) dut15 (
    .clk (clk), .rst (rst),
    .in_data (d15), .in_valid (v15), .in_ready (r15), .in_mode (in_mode),
    .sym_i (i15), .sym_q (q15), .sym_valid (sv15), .sym_ready (sym_ready),
    .sym_last (l15), .busy (b15)
  );

  // Selected-instance view
  logic       sel;  // 0: N=12, 1: N=15
  logic       o_ready, o_valid, o_last, o_busy;
  logic [1:0] o_i, o_q;
  assign o_ready = sel ? r15  : r12;
  assign o_valid = sel ? sv15 : sv12;
  assign o_last  = sel ? l15  : l12;
  assign o_busy  = sel ? b15  : b12;
  assign o_i     = sel ? i15  : i12;
  assign o_q     = sel ? q15  : q12;

  // ---------------- scoreboard ----------------
  logic [4:0]  exp_q[$];     // {sym_i, sym_q, sym_last}
  logic [31:0] pend_data[$];
  logic        pend_mode[$];
  int checks   = 0;
  int failures = 0;

  // 0: always ready, 1: random, 2: stall 3 cycles on the 2nd symbol
  int ready_mode;
  int sym_idx;
  int valid_cycles;
  logic        cur_valid;
  logic [31:0] cur_data;
  logic        holding;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] map_bit(input logic b);
    return b ? 2'b11 : 2'b01;
  endfunction

  // Reference model: list every symbol the codeword must produce
  task automatic push_expected(input logic [31:0] data, input logic mode);
    int n;
    int s;
    logic [1:0] si, sq;
    n = sel ? 15 : 12;
    s = mode ? (n + 1) / 2 : n;
    for (int k = 0; k < s; k++) begin
      if (!mode) begin
        si = map_bit(data[k]);
        sq = 2'b00;
      end else begin
        si = map_bit(data[2*k]);
        sq = (2*k + 1 < n) ? map_bit(data[2*k+1]) : 2'b00;
      end
      exp_q.push_back({si, sq, (k == s - 1)});
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    if (!holding) begin
      holding = (pend_data.size() != 0) && (ready_mode != 1 || $urandom_range(0, 1) == 1);
    end
    cur_valid = holding;
    if (holding) begin
      cur_data = pend_data[0];
      in_mode  = pend_mode[0];
    end else begin
      cur_data = $urandom;
      in_mode  = 1'($urandom_range(0, 1));
    end
    d12 = cur_data[11:0];
    d15 = cur_data[14:0];
    v12 = cur_valid && !sel;
    v15 = cur_valid && sel;
  endtask

  task automatic run(input int budget, input int stop_after);
    int   cyc;
    int   stall;
    bit   took;
    logic exp_rdy;
    cyc = 0; stall = 0; took = 0; sym_idx = 0; valid_cycles = 0;
    while (pend_data.size() != 0 || exp_q.size() != 0 || took) begin
      if (cyc == budget) begin
        check("run_timeout", 32'(cyc), 32'(budget + 1));
        break;
      end
      @(posedge clk); #1; cyc++;
      if (took) begin
        void'(pend_data.pop_front());
        void'(pend_mode.pop_front());
        took = 0;
        holding = 0;
      end
      drive_inputs();
      case (ready_mode)
        0: sym_ready = 1'b1;
        1: sym_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (sym_idx == 1 && stall < 3) begin
            sym_ready = 1'b0;
            stall++;
          end else begin
            sym_ready = 1'b1;
          end
        end
      endcase
      #1;
      exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && sym_ready);
      check("sym_valid", 32'(o_valid), 32'(exp_q.size() != 0));
      check("busy", 32'(o_busy), 32'(exp_q.size() != 0));
      check("in_ready", 32'(o_ready), 32'(exp_rdy));
      if (o_valid) valid_cycles++;
      if (exp_q.size() != 0) begin
        check("symbol", 32'({o_i, o_q, o_last}), 32'(exp_q[0]));
        if (sym_ready) begin
          void'(exp_q.pop_front());
          sym_idx++;
        end
      end
      if (cur_valid && o_ready) begin
        push_expected(cur_data, in_mode);
        took = 1;
      end
      if (stop_after > 0 && sym_idx == stop_after) break;
    end
  endtask

  task automatic queue_word(input logic [31:0] data, input logic mode);
    pend_data.push_back(data);
    pend_mode.push_back(mode);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; sel = 1'b0; v12 = 0; v15 = 0; d12 = '0; d15 = '0;
    in_mode = 1'b0; sym_ready = 1'b0; holding = 0; cur_valid = 0; cur_data = '0;
    ready_mode = 0;

    // Reset state
    #1;
    check("rst_in_ready", 32'(r12), 32'd0);
    check("rst_sym_valid", 32'(sv12), 32'd0);
    check("rst_busy", 32'(b12), 32'd0);
    check("rst_sym_last", 32'(l12), 32'd0);
    check("rst_sym_iq", 32'({i12, q12}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(r12), 32'd1);

    // 1: N=12 BPSK 0x005
    sel = 0; ready_mode = 0;
    queue_word(32'h005, 1'b0); run(200, 0);
    check("t1_sym_count", 32'(sym_idx), 32'd12);

    // 2: N=12 QPSK 0x005
    queue_word(32'h005, 1'b1); run(200, 0);
    check("t2_sym_count", 32'(sym_idx), 32'd6);

    // 3: N=15 QPSK 0x4000, odd-N pad on the last symbol
    sel = 1;
    queue_word(32'h4000, 1'b1); run(200, 0);
    check("t3_sym_count", 32'(sym_idx), 32'd8);

    // 4: backpressure on the 2nd symbol
    sel = 0; ready_mode = 2;
    queue_word(32'hFFF, 1'b0); run(200, 0);
    check("t4_sym_count", 32'(sym_idx), 32'd12);

    // 5: back-to-back codewords, no gap between them
    ready_mode = 0;
    queue_word(32'($urandom), 1'b0); queue_word(32'($urandom), 1'b0);
    run(200, 0);
    check("t5_valid_cycles", 32'(valid_cycles), 32'd24);

    // Random traffic on both widths with random backpressure and mode noise
    ready_mode = 1;
    for (int b = 0; b < 2; b++) begin
      sel = b[0];
      for (int w = 0; w < 20; w++) queue_word($urandom, 1'($urandom_range(0, 1)));
      run(3000, 0);
    end

    // 6: asynchronous reset after 4 QPSK symbols
    sel = 0; ready_mode = 0;
    queue_word(32'($urandom), 1'b1); run(200, 4);
    #2 rst = 1'b1;
    #1;
    check("t6_sym_valid", 32'(sv12), 32'd0);
    check("t6_busy", 32'(b12), 32'd0);
    check("t6_sym_last", 32'(l12), 32'd0);
    check("t6_in_ready", 32'(r12), 32'd0);
    exp_q.delete(); pend_data.delete(); pend_mode.delete();
    holding = 0; v12 = 0; v15 = 0;
    @(posedge clk); #1;
    check("t6_in_ready_held", 32'(r12), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    check("t6_post_in_ready", 32'(r12), 32'd1);
    check("t6_post_valid", 32'(sv12), 32'd0);
    queue_word(32'h001, 1'b1); run(200, 1);
    check("t6_first_sym", 32'({i12, q12}), 32'({2'b11, 2'b01}));
    run(200, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
